// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: conditions the die-select buttons, spins a modulo-N BCD
// counter while the winning button is held and latches the result for display.
module dice_roll_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int ANIM_CYCLES     = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_raw,
  input  logic       btn_pol,
  output logic [6:0] die_sel,
  output logic       rolling,
  output logic       result_valid,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       tens_blank,
  output logic       ones_blank
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ANIM_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ROLLING, RELEASE, SHOW} state_t;

  state_t            state;
  logic [6:0]        sync1;
  logic [6:0]        btn_s;
  logic [2:0]        winner;
  logic [2:0]        pick;
  logic              from_show;
  logic [DEB_W-1:0]  deb_cnt;
  logic [ANIM_W-1:0] anim_cnt;
  logic [3:0]        cnt_tens;
  logic [3:0]        cnt_ones;
  logic              cnt_hund;
  logic [3:0]        n_tens;
  logic [3:0]        n_ones;
  logic              at_max;
  logic [3:0]        nxt_tens;
  logic [3:0]        nxt_ones;
  logic              nxt_hund;
  logic              nxt_tens_blank;
  logic              win_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      btn_s <= '0;
    end else begin
      sync1 <= btn_raw ^ {7{~btn_pol}};
      btn_s <= sync1;
    end
  end

  // Lowest index wins, so scan from the top and let lower bits overwrite.
  always_comb begin
    pick = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (btn_s[i]) pick = 3'(i);
    end
  end

  always_comb begin
    n_tens = 4'd0;
    n_ones = 4'd0;
    case (winner)
      3'd0:    n_ones = 4'd4;
      3'd1:    n_ones = 4'd6;
      3'd2:    n_ones = 4'd8;
      3'd3:    n_tens = 4'd1;
      3'd4:    begin n_tens = 4'd1; n_ones = 4'd2; end
      3'd5:    n_tens = 4'd2;
      default: begin n_tens = 4'd0; n_ones = 4'd0; end
    endcase
  end

  // d100 reaches its maximum only through the hundred flag.
  assign at_max  = (winner == 3'd6) ? cnt_hund
                 : (!cnt_hund && cnt_tens == n_tens && cnt_ones == n_ones);
  assign win_btn = btn_s[winner];

  always_comb begin
    nxt_tens = cnt_tens;
    nxt_ones = cnt_ones;
    nxt_hund = cnt_hund;
    if (at_max) begin
      nxt_tens = 4'd0;
      nxt_ones = 4'd1;
      nxt_hund = 1'b0;
    end else if (cnt_ones == 4'd9) begin
      nxt_ones = 4'd0;
      if (cnt_tens == 4'd9) begin
        nxt_tens = 4'd0;
        nxt_hund = 1'b1;
      end else begin
        nxt_tens = cnt_tens + 4'd1;
      end
    end else begin
      nxt_ones = cnt_ones + 4'd1;
    end
  end

  assign nxt_tens_blank = (nxt_tens == 4'd0) && !nxt_hund;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      winner       <= 3'd0;
      from_show    <= 1'b0;
      deb_cnt      <= '0;
      anim_cnt     <= '0;
      cnt_tens     <= 4'd0;
      cnt_ones     <= 4'd0;
      cnt_hund     <= 1'b0;
      die_sel      <= 7'd0;
      rolling      <= 1'b0;
      result_valid <= 1'b0;
      disp_tens    <= 4'd0;
      disp_ones    <= 4'd0;
      tens_blank   <= 1'b1;
      ones_blank   <= 1'b1;
    end else begin
      // Counter and animation keep running through a release bounce.
      if (state == ROLLING || state == RELEASE) begin
        cnt_tens <= nxt_tens;
        cnt_ones <= nxt_ones;
        cnt_hund <= nxt_hund;
        if (anim_cnt == ANIM_LAST) begin
          anim_cnt   <= '0;
          disp_tens  <= nxt_tens;
          disp_ones  <= nxt_ones;
          tens_blank <= nxt_tens_blank;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end

      case (state)
        IDLE, SHOW: begin
          if (|btn_s) begin
            state        <= DEBOUNCE;
            winner       <= pick;
            from_show    <= (state == SHOW);
            deb_cnt      <= '0;
            result_valid <= 1'b0;
          end
        end
        DEBOUNCE: begin
          if (win_btn) begin
            if (deb_cnt == DEB_LAST) begin
              state      <= ROLLING;
              rolling    <= 1'b1;
              die_sel    <= 7'd1 << winner;
              cnt_tens   <= 4'd0;
              cnt_ones   <= 4'd1;
              cnt_hund   <= 1'b0;
              anim_cnt   <= '0;
              disp_tens  <= 4'd0;
              disp_ones  <= 4'd1;
              tens_blank <= 1'b1;
              ones_blank <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            state        <= from_show ? SHOW : IDLE;
            result_valid <= from_show;
          end
        end
        ROLLING: begin
          if (!win_btn) begin
            state   <= RELEASE;
            deb_cnt <= '0;
          end
        end
        RELEASE: begin
          if (win_btn) begin
            state <= ROLLING;
          end else if (deb_cnt == DEB_LAST) begin
            state        <= SHOW;
            rolling      <= 1'b0;
            result_valid <= 1'b1;
            disp_tens    <= nxt_tens;
            disp_ones    <= nxt_ones;
            tens_blank   <= nxt_tens_blank;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl: expected rolls are queued at press time
// from a 1 + (R mod N) model and checked by a monitor when result_valid rises.
module tb_dice_roll_ctrl;

  localparam int DEB  = 4;
  localparam int ANIM = 8;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_pol;
  logic [6:0] btn_main;
  logic [6:0] btn_extra;
  logic [6:0] btn_raw;
  logic [6:0] die_sel;
  logic       rolling;
  logic       result_valid;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       tens_blank;
  logic       ones_blank;

  typedef struct packed {
    logic [6:0] die;
    logic       blank;
    logic [3:0] tens;
    logic [3:0] ones;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   die_n[7] = '{4, 6, 8, 10, 12, 20, 100};
  logic prev_rv = 1'b0;

  assign btn_raw = (btn_main | btn_extra) ^ {7{~btn_pol}};

  always #5 clk = ~clk;

  dice_roll_ctrl #(.DEBOUNCE_CYCLES(DEB), .ANIM_CYCLES(ANIM)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_pol(btn_pol),
    .die_sel(die_sel), .rolling(rolling), .result_valid(result_valid),
    .disp_tens(disp_tens), .disp_ones(disp_ones),
    .tens_blank(tens_blank), .ones_blank(ones_blank)
  );

  function automatic logic [8:0] encode(input int v);
    logic b;
    if (v == 100) return 9'd0;
    b = (v < 10);
    return {b, 4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic exp_t model(input int idx, input int r);
    exp_t       e;
    logic [8:0] d;
    d       = encode(1 + (r % die_n[idx]));
    e.die   = 7'd1 << idx;
    e.blank = d[8];
    e.tens  = d[7:4];
    e.ones  = d[3:0];
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] mask);
    btn_main = mask;
  endtask

  task automatic check_reset_values();
    check_output("rst_die_sel", 32'(die_sel), 32'd0);
    check_output("rst_rolling", 32'(rolling), 32'd0);
    check_output("rst_result_valid", 32'(result_valid), 32'd0);
    check_output("rst_disp_tens", 32'(disp_tens), 32'd0);
    check_output("rst_disp_ones", 32'(disp_ones), 32'd0);
    check_output("rst_tens_blank", 32'(tens_blank), 32'd1);
    check_output("rst_ones_blank", 32'(ones_blank), 32'd1);
  endtask

  // R is the pin hold time from first press to final release, bounces included.
  task automatic roll(input logic [6:0] mask, input int win, input int h1,
                      input int gap, input int h2, input bit scored);
    int lat;
    int r;
    r   = (gap > 0) ? (h1 + gap + h2) : h1;
    lat = -1;
    if (scored) sb_q.push_back(model(win, r));
    @(negedge clk);
    apply_stimulus(mask);
    for (int i = 1; i <= h1; i++) begin
      @(negedge clk);
      if (lat < 0 && rolling) lat = i;
    end
    check_output("roll_latency", 32'(lat), 32'(LAT));
    apply_stimulus(7'd0);
    if (gap > 0) begin
      repeat (gap) @(negedge clk);
      apply_stimulus(mask);
      repeat (h2) @(negedge clk);
      apply_stimulus(7'd0);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check_output({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic anim_check(input int cycles);
    int waited;
    waited = 0;
    while (!rolling && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check_output("anim_start", 32'(rolling), 32'd1);
    for (int k = 0; k < cycles; k++) begin
      check_output("anim_disp", 32'({tens_blank, disp_tens, disp_ones}),
                   32'(encode(1 + ANIM * (k / ANIM))));
      @(negedge clk);
    end
  endtask

  // Monitor: every rising result_valid must match the oldest queued roll.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (result_valid && !prev_rv) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_show", 32'(result_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_output("show_value", 32'({die_sel, tens_blank, disp_tens, disp_ones}),
                       32'({e.die, e.blank, e.tens, e.ones}));
          check_output("show_flags", 32'({rolling, ones_blank}), 32'd0);
        end
      end
      prev_rv = result_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx, h1, gap, h2;
    rst_n     = 1'b0;
    btn_pol   = 1'b1;
    btn_main  = 7'd0;
    btn_extra = 7'd0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_output("idle_hold", 32'({rolling, result_valid, die_sel, ones_blank}), 32'd1);
    end

    // A 3-cycle d20 glitch is shorter than the debounce window.
    apply_stimulus(7'd1 << 5);
    repeat (3) @(negedge clk);
    apply_stimulus(7'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("glitch_idle", 32'({rolling, result_valid, die_sel}), 32'd0);
    end

    $display("[TB] d6 roll, R=13");
    roll(7'd1 << 1, 1, 13, 0, 0, 1'b1);
    wait_done("d6");

    $display("[TB] d100 roll, R=99, with animation check");
    fork
      roll(7'd1 << 6, 6, 99, 0, 0, 1'b1);
      anim_check(40);
    join
    wait_done("d100_99");
    roll(7'd1 << 6, 6, 100, 0, 0, 1'b1);
    wait_done("d100_100");

    $display("[TB] d8 and d20 together");
    roll((7'd1 << 2) | (7'd1 << 5), 2, 30, 0, 0, 1'b1);
    wait_done("priority");

    $display("[TB] d12 pressed while d4 rolls");
    fork
      roll(7'd1, 0, 60, 0, 0, 1'b1);
      begin
        repeat (20) @(negedge clk);
        btn_extra = 7'd1 << 4;
        repeat (10) @(negedge clk);
        btn_extra = 7'd0;
      end
    join
    wait_done("ignore_d12");

    $display("[TB] active-low d10 with release bounce");
    btn_pol = 1'b0;
    repeat (3) @(negedge clk);
    roll(7'd1 << 3, 3, 20, 2, 15, 1'b1);
    wait_done("pol_low");

    for (int n = 0; n < 8; n++) begin
      btn_pol = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      idx = $urandom_range(0, 6);
      h1  = $urandom_range(10, 120);
      gap = $urandom_range(0, 3);
      h2  = $urandom_range(1, 20);
      roll(7'd1 << idx, idx, h1, gap, h2, 1'b1);
      wait_done("random");
    end

    $display("[TB] reset during RELEASE");
    btn_pol = 1'b1;
    repeat (3) @(negedge clk);
    roll(7'd1 << 4, 4, 20, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_output("post_reset_idle", 32'({rolling, result_valid, die_sel}), 32'd0);
    end

    roll(7'd1, 0, 25, 0, 0, 1'b1);
    wait_done("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
